sfifo_rd_stream: RTL and testbench

SFIFO_RD_STREAM -- requirements
Module: sfifo_rd_stream

---
 rtl/sfifo_pkg.sv | 19 +
 rtl/sfifo_rd_stream.sv | 110 +++++++++++
 tb/tb_sfifo_rd_stream.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sfifo_pkg.sv
// Shared types for the synchronous-FIFO read-side streaming adapter.
package sfifo_pkg;

  localparam int BEAT_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Words already buffered plus the word still on its way from the FIFO.
  function automatic logic [1:0] occ_pending(occ_e occ, logic inflight);
    logic [1:0] lvl;
    lvl = occ;
    return lvl + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/sfifo_rd_stream.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream via a 2-entry skid buffer.
// Optional beat counter enabled by defining SFIFO_RD_BEAT_CNT_EN; otherwise beat_cnt is tied to 0.
module sfifo_rd_stream
  import sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  empty,
  output logic                  rden,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic       pop;
  logic       cap;
  logic [1:0] pending;

  assign m_valid = (occ_q != EMPTY);
  assign m_data  = buf0_q;
  assign pop     = m_valid & m_ready;
  assign cap     = inflight_q;
  assign pending = occ_pending(occ_q, inflight_q);

  // A new read may be issued when it is guaranteed a slot, counting the pop this cycle.
  assign rden = ~empty & arst_n &
                ((pending < 2'd2) | ((pending == 2'd2) & pop));

  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rden;
    unique case (occ_q)
      EMPTY: begin
        if (cap) begin
          buf0_d = rdata;
          occ_d  = ONE;
        end
      end
      ONE: begin
        unique case ({cap, pop})
          2'b11: buf0_d = rdata;
          2'b10: begin
            buf1_d = rdata;
            occ_d  = TWO;
          end
          2'b01: occ_d = EMPTY;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (cap) buf1_d = rdata;
          else     occ_d  = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

`ifdef SFIFO_RD_BEAT_CNT_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) beat_cnt_q <= '0;
    else         beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = '0;
`endif

`ifndef SYNTHESIS
  rden_not_when_empty: assert property (@(posedge clk) disable iff (!arst_n) rden |-> !empty);
  no_buffer_overflow:  assert property (@(posedge clk) disable iff (!arst_n)
                                        !((occ_q == TWO) && inflight_q && !pop));
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Scoreboard bench for sfifo_rd_stream: directed FIFO contents, monitor compares every accepted beat.
`timescale 1ns/1ps
module tb_sfifo_rd_stream;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          empty;
  logic          rden;
  logic [DW-1:0] rdata;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [15:0]   beat_cnt;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] mem [256];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  assign empty = (rd_ptr == wr_ptr);

  sfifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .empty    (empty),
    .rden     (rden),
    .rdata    (rdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .beat_cnt (beat_cnt)
  );

  // FIFO model: data appears on rdata one cycle after rden.
  initial begin
    rdata = '0;
    forever begin
      @(posedge clk);
      if (rden === 1'b1) begin
        rdata  <= mem[rd_ptr % 256];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef SFIFO_RD_BEAT_CNT_EN
    return 32'(n % 65536);
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: scoreboard pops, stall stability, rden/empty rule.
  initial begin
    logic [DW-1:0] held_d;
    logic          held_v;
    logic [DW-1:0] e;
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (rden === 1'b1) check("rden_while_empty", {31'd0, empty}, 32'd0);
      if (held_v && m_valid === 1'b1) check("stall_stable", m_data, held_d);
      if (arst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_data, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e);
        end
`ifndef SFIFO_RD_BEAT_CNT_EN
        check("beat_cnt_tied", {16'd0, beat_cnt}, 32'd0);
`endif
      end
      held_v = (arst_n === 1'b1) && (m_valid === 1'b1) && (m_ready !== 1'b1);
      held_d = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes n words base.. into the FIFO; only words from index skip on are expected on the stream.
  task automatic load(input logic [31:0] base, input int n, input int skip);
    for (int i = 0; i < n; i++) begin
      mem[(wr_ptr + i) % 256] = base + 32'(i);
      if (i >= skip) exp_q.push_back(base + 32'(i));
    end
    wr_ptr = wr_ptr + n;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    logic mv_v [12];
    logic rd_v [12];
    int   cnt_a, cnt_b, n;

    // Reset held with a word waiting in the FIFO.
    arst_n  = 1'b0;
    m_ready = 1'b0;
    load(32'h01, 1, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_rden", {31'd0, rden}, 32'd0);
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    end
    check("rst_m_data", m_data, 32'd0);
    tick();
    arst_n  = 1'b1;
    m_ready = 1'b1;
    wait_drain("drain_after_reset", 20);
    check("cnt_after_reset_word", {16'd0, beat_cnt}, exp_cnt(1));

    // Streaming eight words at full rate.
    load(32'h10, 8, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rd_v[k] = rden;
      mv_v[k] = m_valid;
    end
    check("stream_first_rden", {31'd0, rd_v[0]}, 32'd1);
    check("stream_valid_n1", {31'd0, mv_v[1]}, 32'd0);
    check("stream_valid_n2", {31'd0, mv_v[2]}, 32'd1);
    cnt_a = 0;
    for (int k = 2; k < 10; k++) if (mv_v[k] === 1'b1) cnt_a++;
    check("stream_consecutive", 32'(cnt_a), 32'd8);
    check("stream_valid_end", {31'd0, mv_v[10]}, 32'd0);
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    tick();
    check("stream_beat_cnt", {16'd0, beat_cnt}, exp_cnt(9));

    // Backpressure after the first beat.
    load(32'h20, 5, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_valid !== 1'b1 && n < 10);
    check("bp_first_valid", {31'd0, m_valid}, 32'd1);
    check("bp_first_latency", 32'(n), 32'd3);
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check("bp_rden_stop", {31'd0, rden}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_rden_held", {31'd0, rden}, 32'd0);
      check("bp_m_data", m_data, 32'h21);
    end
    check("bp_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
    tick();
    m_ready = 1'b1;
    wait_drain("bp_drain", 20);
    check("bp_beat_cnt", {16'd0, beat_cnt}, exp_cnt(14));

    // Single word: empty rises right after the read.
    load(32'h30, 1, 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rden === 1'b1) cnt_a++;
      if (m_valid === 1'b1) cnt_b++;
    end
    check("one_word_rden", 32'(cnt_a), 32'd1);
    check("one_word_beats", 32'(cnt_b), 32'd1);
    check("one_word_drained", 32'(exp_q.size()), 32'd0);
    tick();
    check("one_word_beat_cnt", {16'd0, beat_cnt}, exp_cnt(15));

    // Reset with two words buffered; those two are discarded.
    m_ready = 1'b0;
    load(32'h40, 4, 2);
    for (int k = 0; k < 6; k++) tick();
    check("mid_full_valid", {31'd0, m_valid}, 32'd1);
    check("mid_full_data", m_data, 32'h40);
    check("mid_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
    arst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rden", {31'd0, rden}, 32'd0);
    tick();
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_cnt", {16'd0, beat_cnt}, 32'd0);
    check("mid_rst_data", m_data, 32'd0);
    tick();
    arst_n  = 1'b1;
    m_ready = 1'b1;
    wait_drain("mid_drain", 20);
    check("mid_beat_cnt", {16'd0, beat_cnt}, exp_cnt(2));

`ifdef SFIFO_RD_BEAT_CNT_EN
    // 65537 beats wrap the counter to 1.
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    for (int j = 0; j < 65537; j++) exp_q.push_back(32'((wr_ptr + j) % 256));
    wr_ptr = wr_ptr + 65537;
    wait_drain("wrap_drain", 70000);
    check("wrap_beat_cnt", {16'd0, beat_cnt}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
